// File: rtl/cnt60_disp_src_pkg.sv
// Shared constants for the MM:SS stopwatch display source.
// Segment codes are active-low, bit0..6 = a..g, bit7 = decimal point.
package cnt60_disp_src_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int unsigned DP_BIT = 7;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 blank the digit.
module seg7_dec
    import cnt60_disp_src_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cnt60_disp_src.sv
// MM:SS BCD stopwatch with start/stop and clear buttons, driving four registered
// active-low segment buses and a free-running scanner ENABLE strobe.
module cnt60_disp_src
    import cnt60_disp_src_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START_STOP,
    input  logic       CLEAR,
    output logic       ENABLE,
    output logic [7:0] L1,
    output logic [7:0] L2,
    output logic [7:0] L3,
    output logic [7:0] L4,
    output logic       CARRY
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [1:0]    ss_sync_q, clr_sync_q;
    logic          ss_prev_q, clr_prev_q;
    logic          run_q, run_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [3:0]    su_q, st_q, mu_q, mt_q;
    logic [3:0]    su_d, st_d, mu_d, mt_d;
    logic          carry_q, carry_d;
    logic [SW-1:0] scan_q;
    logic [7:0]    l1_q, l2_q, l3_q, l4_q, l2_d;
    logic [7:0]    seg_mt, seg_mu, seg_st, seg_su;
    logic          ss_rise, clr_rise, tick;

    assign ss_rise  = ss_sync_q[1] & ~ss_prev_q;
    assign clr_rise = clr_sync_q[1] & ~clr_prev_q;
    assign tick     = run_q && (presc_q == TICK_LAST);

    always_comb begin
        run_d   = run_q;
        presc_d = presc_q;
        su_d    = su_q;
        st_d    = st_q;
        mu_d    = mu_q;
        mt_d    = mt_q;
        carry_d = 1'b0;
        if (clr_rise) begin
            // Clear beats both a coincident tick and a coincident start/stop.
            run_d   = 1'b0;
            presc_d = '0;
            su_d    = 4'd0;
            st_d    = 4'd0;
            mu_d    = 4'd0;
            mt_d    = 4'd0;
        end else begin
            if (ss_rise) run_d = ~run_q;
            if (tick) begin
                presc_d = '0;
                if (su_q != 4'd9) su_d = su_q + 4'd1;
                else begin
                    su_d = 4'd0;
                    if (st_q != 4'd5) st_d = st_q + 4'd1;
                    else begin
                        st_d = 4'd0;
                        if (mu_q != 4'd9) mu_d = mu_q + 4'd1;
                        else begin
                            mu_d = 4'd0;
                            if (mt_q != 4'd5) mt_d = mt_q + 4'd1;
                            else begin
                                mt_d    = 4'd0;
                                carry_d = 1'b1;
                            end
                        end
                    end
                end
            end else if (run_q) begin
                presc_d = presc_q + TW'(1);
            end
        end
    end

    seg7_dec u_dec_mt (.bcd(mt_q), .seg(seg_mt));
    seg7_dec u_dec_mu (.bcd(mu_q), .seg(seg_mu));
    seg7_dec u_dec_st (.bcd(st_q), .seg(seg_st));
    seg7_dec u_dec_su (.bcd(su_q), .seg(seg_su));

    // Colon dot is lit (low) while running.
    always_comb begin
        l2_d         = seg_mu;
        l2_d[DP_BIT] = ~run_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ss_sync_q  <= '0;
            clr_sync_q <= '0;
            ss_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            run_q      <= 1'b0;
            presc_q    <= '0;
            su_q       <= 4'd0;
            st_q       <= 4'd0;
            mu_q       <= 4'd0;
            mt_q       <= 4'd0;
            carry_q    <= 1'b0;
            scan_q     <= '0;
            l1_q       <= SEG_0;
            l2_q       <= SEG_0;
            l3_q       <= SEG_0;
            l4_q       <= SEG_0;
        end else begin
            ss_sync_q  <= {ss_sync_q[0], START_STOP};
            clr_sync_q <= {clr_sync_q[0], CLEAR};
            ss_prev_q  <= ss_sync_q[1];
            clr_prev_q <= clr_sync_q[1];
            run_q      <= run_d;
            presc_q    <= presc_d;
            su_q       <= su_d;
            st_q       <= st_d;
            mu_q       <= mu_d;
            mt_q       <= mt_d;
            carry_q    <= carry_d;
            scan_q     <= (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
            l1_q       <= seg_mt;
            l2_q       <= l2_d;
            l3_q       <= seg_st;
            l4_q       <= seg_su;
        end
    end

    assign ENABLE = (scan_q == SCAN_LAST);
    assign CARRY  = carry_q;
    assign L1     = l1_q;
    assign L2     = l2_q;
    assign L3     = l3_q;
    assign L4     = l4_q;

endmodule

// File: tb/tb_cnt60_disp_src.sv
// Bench for cnt60_disp_src: a seconds-count model checked every cycle, plus
// directed scenarios with hand-computed display values.
module tb_cnt60_disp_src;

    localparam int TD = 4;
    localparam int SD = 3;
    localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss = 1'b0;
    logic clr = 1'b0;
    logic enable, carry;
    logic [7:0] l1, l2, l3, l4;

    int checks = 0;
    int errors = 0;

    cnt60_disp_src #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .CLK(clk), .RESET_N(rst_n), .START_STOP(ss), .CLEAR(clr),
        .ENABLE(enable), .L1(l1), .L2(l2), .L3(l3), .L4(l4), .CARRY(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: elapsed seconds as one integer; buttons seen through a raw-sample history.
    int   m_secs = 0, m_pre = 0, m_scan = 0;
    bit   m_run = 0, m_valid = 0, m_carry = 0, m_en = 0;
    bit   ss_h1 = 0, ss_h2 = 0, ss_h3 = 0, clr_h1 = 0, clr_h2 = 0, clr_h3 = 0;
    logic [7:0] m_l [4];

    function automatic logic [7:0] disp(input int secs, input bit run, input int pos);
        logic [7:0] s;
        case (pos)
            0: s = SEG[secs / 600];
            1: s = (SEG[(secs / 60) % 10] & 8'h7F) | (run ? 8'h00 : 8'h80);
            2: s = SEG[(secs % 60) / 10];
            default: s = SEG[secs % 10];
        endcase
        return s;
    endfunction

    always @(posedge clk) begin
        bit ss_ev, clr_ev, tk;
        if (!rst_n) begin
            m_secs = 0; m_pre = 0; m_scan = 0; m_run = 0; m_carry = 0; m_en = 0;
            ss_h1 = 0; ss_h2 = 0; ss_h3 = 0; clr_h1 = 0; clr_h2 = 0; clr_h3 = 0;
            for (int i = 0; i < 4; i++) m_l[i] = 8'hC0;
            m_valid = 1;
        end else begin
            ss_ev  = ss_h2 && !ss_h3;
            clr_ev = clr_h2 && !clr_h3;
            ss_h3 = ss_h2; ss_h2 = ss_h1; ss_h1 = ss;
            clr_h3 = clr_h2; clr_h2 = clr_h1; clr_h1 = clr;
            for (int i = 0; i < 4; i++) m_l[i] = disp(m_secs, m_run, i);
            tk = m_run && (m_pre == TD - 1);
            m_carry = 0;
            if (clr_ev) begin
                m_secs = 0; m_pre = 0; m_run = 0;
            end else begin
                if (tk) begin
                    m_pre = 0;
                    if (m_secs == 3599) begin m_secs = 0; m_carry = 1; end
                    else m_secs++;
                end else if (m_run) m_pre++;
                if (ss_ev) m_run = !m_run;
            end
            m_scan = (m_scan + 1) % SD;
        end
        m_en = (m_scan == SD - 1);
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("L1", {24'd0, l1}, {24'd0, m_l[0]});
            chk("L2", {24'd0, l2}, {24'd0, m_l[1]});
            chk("L3", {24'd0, l3}, {24'd0, m_l[2]});
            chk("L4", {24'd0, l4}, {24'd0, m_l[3]});
            chk("ENABLE", {31'd0, enable}, {31'd0, m_en});
            chk("CARRY", {31'd0, carry}, {31'd0, m_carry});
        end
    end

    int carry_cnt = 0;
    always @(negedge clk) if (rst_n && carry === 1'b1) carry_cnt++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk_disp(input string name, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4);
        chk({name, "_L1"}, {24'd0, l1}, {24'd0, e1});
        chk({name, "_L2"}, {24'd0, l2}, {24'd0, e2});
        chk({name, "_L3"}, {24'd0, l3}, {24'd0, e3});
        chk({name, "_L4"}, {24'd0, l4}, {24'd0, e4});
    endtask

    initial begin
        int en_cnt;
        int e;
        // Reset and idle
        cyc(2);
        chk_disp("reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("reset_EN", {31'd0, enable}, 32'd0);
        chk("reset_CARRY", {31'd0, carry}, 32'd0);
        rst_n = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            if (enable === 1'b1) en_cnt++;
        end
        chk("enable_rate", en_cnt, 32'd3);
        chk_disp("idle", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Start at edge P: run after P+3, tick every 4 edges from P+7
        ss = 1'b1; cyc(1); ss = 1'b0;
        cyc(3);
        chk_disp("run_dot", 8'hC0, 8'h40, 8'hC0, 8'hC0);
        cyc(40);
        chk_disp("t0010", 8'hC0, 8'h40, 8'hF9, 8'hC0);

        // Continue to 59:59 then wrap; wrap tick is tick 3600 at edge P+3+4*3600
        e = 3 + 4 * 3600;
        cyc(e - 44);
        chk("wrap_CARRY", {31'd0, carry}, 32'd1);
        chk_disp("t5959", 8'h92, 8'h10, 8'h92, 8'h90);
        cyc(1);
        chk("wrap_CARRY_end", {31'd0, carry}, 32'd0);
        chk_disp("wrap", 8'hC0, 8'h40, 8'hC0, 8'hC0);
        chk("carry_count", carry_cnt, 32'd1);

        // Clear while running
        clr = 1'b1; cyc(1); clr = 1'b0;
        cyc(6);
        chk_disp("cleared", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Run 5 ticks, stop with prescaler at 2, resume
        ss = 1'b1; cyc(1); ss = 1'b0;
        cyc(21);
        ss = 1'b1; cyc(1); ss = 1'b0;
        cyc(20);
        chk_disp("stop0005", 8'hC0, 8'hC0, 8'hC0, 8'h92);
        ss = 1'b1; cyc(1); ss = 1'b0;
        cyc(4);
        chk_disp("resume_pre", 8'hC0, 8'h40, 8'hC0, 8'h92);
        cyc(1);
        chk_disp("resume0006", 8'hC0, 8'h40, 8'hC0, 8'h82);

        // Start/stop and clear together at 00:07: clear wins
        cyc(1);
        ss = 1'b1; clr = 1'b1; cyc(1); ss = 1'b0; clr = 1'b0;
        cyc(5);
        chk_disp("both", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        cyc(10);
        chk_disp("both_hold", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Reset while running at 00:03 with prescaler at 2
        ss = 1'b1; cyc(1); ss = 1'b0;
        cyc(16);
        chk_disp("pre_reset", 8'hC0, 8'h40, 8'hC0, 8'hB0);
        rst_n = 1'b0;
        cyc(1);
        chk_disp("mid_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("mid_reset_EN", {31'd0, enable}, 32'd0);
        chk("mid_reset_CARRY", {31'd0, carry}, 32'd0);
        rst_n = 1'b1;
        cyc(20);
        chk_disp("post_reset", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("total_carry", carry_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnt60_disp_src.md
Name: cnt60_disp_src

Overview:
- Upstream source for the 4-digit multiplexed 7-segment scanner.
- Keeps an MM:SS stopwatch (00:00–59:59) in BCD, controlled by start/stop and clear buttons.
- Generates the scanner's ENABLE strobe and drives the four segment buses L1..L4 (L1 = leftmost digit).
- Segment outputs are registered, active-low and ready for direct connection.

Parameters:
- TICK_DIV, 50000000: CLK cycles per 1 s count tick. Minimum 2. Sim uses 4.
- SCAN_DIV, 50000: CLK cycles between ENABLE strobes. Minimum 2. Sim uses 3.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START_STOP  in  1  raw button, asynchronous; each rising edge toggles run/stop.
- CLEAR  in  1  raw button, asynchronous; rising edge stops the timer and zeros it.
- ENABLE  out  1  one-CLK pulse every SCAN_DIV cycles; drives the scanner's ENABLE.
- L1  out  8  minute tens segments.
- L2  out  8  minute units segments; bit7 is the colon dot.
- L3  out  8  second tens segments.
- L4  out  8  second units segments.
- CARRY  out  1  one-CLK pulse on the 59:59 -> 00:00 wrap.

Behaviour:
- Reset: already decided — one clock CLK; reset RESET_N is synchronous and active-low. On the first CLK edge with RESET_N=0:
  - digits, prescaler, scan counter, run flag and sync flops are all cleared;
  - ENABLE=0, CARRY=0;
  - L1..L4 = 8'hC0 ("0", dot off).
- Segment code: bit0..6 = a..g, bit7 = dp, 0 = lit. Digit codes:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
- Buttons:
  - each button passes through a 2-flop synchronizer, then a previous-value register; a rise is sync=1 and prev=0;
  - the internal event occurs 3 CLK edges after the raw input rises;
  - no debounce (done externally).
- Run flag:
  - a START_STOP rise toggles it;
  - a CLEAR rise forces it to 0;
  - if both rise in the same cycle, CLEAR wins (run=0).
- Prescaler:
  - counts 0..TICK_DIV-1 only while run=1; holds its value while stopped;
  - tick = 1 for one cycle when prescaler = TICK_DIV-1 and run=1; prescaler then wraps to 0.
- BCD chain on tick:
  - su 0..9; on 9 it wraps to 0 and carries into st;
  - st 0..5, carries into mu;
  - mu 0..9, carries into mt;
  - mt 0..5;
  - 59:59 + tick -> 00:00, with CARRY=1 in the same cycle the digits update.
- CLEAR event: digits and prescaler go to 0 in the same edge as run=0. It overrides a coincident tick (no carry, no CARRY pulse).
- Outputs:
  - L1..L4 are registered from the decoded digits, so they change 1 CLK after the digit registers;
  - L2 bit7 = ~run (dot lit while running).
- Scan: a free-running counter 0..SCAN_DIV-1, independent of run and CLEAR. ENABLE=1 when the counter equals SCAN_DIV-1.
- Reset mid-count: full return to the reset state on that edge, with no CARRY pulse.

Decomposition:
- Shared package: the segment code constants (SEG_0..SEG_9, SEG_BLANK = 8'hFF) and the DP bit index 7.
- Sub-module seg7_dec: purely combinational 4-bit BCD to 8-bit active-low segment decoder.
  - 10..15 -> SEG_BLANK.
  - Instantiated four times.

Test Plan (TICK_DIV=4, SCAN_DIV=3):
- Hold RESET_N=0 for 2 cycles, then release -> L1..L4 = C0, ENABLE pulses every 3rd cycle, ENABLE=0/CARRY=0 immediately after reset, digits stay 00:00 with no button input.
- Pulse START_STOP -> run=1 three edges later, L2 = 40; after 10 ticks (40 cycles) L3=F9 ("1"), L4=C0, showing 00:10.
- Preload via ticks to 59:58 and run -> after 2 ticks L1..L4 = C0,40,C0,C0 and CARRY pulses once, in the wrap cycle.
- Run for 5 ticks, pulse START_STOP -> counting stops at 00:05, L2 = C0, prescaler holds; pulse again -> the next tick arrives after the remaining prescaler cycles.
- START_STOP and CLEAR rise in the same cycle while running at 00:07 -> display 00:00, run=0, no toggle back to run.
- Drive RESET_N=0 while running at 00:03 and the prescaler is at 2 -> next edge shows all outputs at reset values; after release, no tick occurs until START_STOP is pressed.
